// File: rtl/sprite_renderer.sv
// sprite_renderer: reads texels for a scaled 16x16 sprite and composites them over a background colour.
// Latency: hcount/vcount/bg_rgb -> vga_rgb is MEM_LAT+2 clk; mem_x/mem_y/mem_shape are registered 1 clk after hcount/vcount.
// Backpressure: none; the pipeline advances every clk in lockstep with the raster.
//
// Ports:
//   clk, Reset (async, active-low)
//   hcount/vcount/video_on            raster position from the VGA timing generator
//   sprite_x/y/shape/en, bg_rgb       sprite request (sampled at frame start) and background colour
//   mem_x/mem_y/mem_shape -> mem_R/G/B/A   texel address out, texel bits back MEM_LAT clk later (MEM_LAT 1..3)
//   vga_rgb, sprite_hit, frame_drawn  composited pixel, opaque-texel flag, sticky "sprite drawn this frame"
module sprite_renderer #(
    parameter int HW         = 10,
    parameter int SCALE_LOG2 = 2,
    parameter int MEM_LAT    = 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic [HW-1:0] hcount,
    input  logic [HW-1:0] vcount,
    input  logic          video_on,
    input  logic [HW-1:0] sprite_x,
    input  logic [HW-1:0] sprite_y,
    input  logic [1:0]    sprite_shape,
    input  logic          sprite_en,
    input  logic [11:0]   bg_rgb,
    output logic [3:0]    mem_x,
    output logic [3:0]    mem_y,
    output logic [1:0]    mem_shape,
    input  logic          mem_R,
    input  logic          mem_G,
    input  logic          mem_B,
    input  logic          mem_A,
    output logic [11:0]   vga_rgb,
    output logic          sprite_hit,
    output logic          frame_drawn
);

    localparam int          S   = 16 << SCALE_LOG2;
    localparam logic [HW:0] BOX = (HW+1)'(S);

    // Per-pixel side information that travels alongside the memory access.
    typedef struct packed {
        logic        in_box;
        logic        vid;
        logic [11:0] bg;
    } pix_t;

    logic [HW-1:0] shadow_x_q, shadow_x_d;
    logic [HW-1:0] shadow_y_q, shadow_y_d;
    logic [1:0]    shadow_shape_q, shadow_shape_d;
    logic          shadow_en_q, shadow_en_d;

    logic [3:0]    mem_x_q, mem_x_d;
    logic [3:0]    mem_y_q, mem_y_d;
    logic [1:0]    mem_shape_q, mem_shape_d;
    pix_t          s0_q, s0_d;
    pix_t          dly_q [MEM_LAT];
    pix_t          dly_d [MEM_LAT];

    logic [11:0]   vga_rgb_q, vga_rgb_d;
    logic          sprite_hit_q, sprite_hit_d;
    logic          frame_drawn_q, frame_drawn_d;

    logic          frame_start;
    logic [HW:0]   h_end, v_end;
    logic          in_box;
    logic [3:0]    tex_x, tex_y;
    pix_t          al;

    // Shadow registers: the frame-start pixel already uses the newly latched
    // values, so a sprite placed at (0,0) gets its first pixel drawn.
    always_comb begin
        frame_start    = (hcount == '0) && (vcount == '0);
        shadow_x_d     = shadow_x_q;
        shadow_y_d     = shadow_y_q;
        shadow_shape_d = shadow_shape_q;
        shadow_en_d    = shadow_en_q;
        if (frame_start) begin
            shadow_x_d     = sprite_x;
            shadow_y_d     = sprite_y;
            shadow_shape_d = sprite_shape;
            shadow_en_d    = sprite_en;
        end
    end

    // Box test and texel address. The box end is one bit wider than the
    // coordinates so a sprite hanging off the right/bottom edge clips
    // instead of wrapping around to column/row 0.
    always_comb begin
        h_end  = {1'b0, shadow_x_d} + BOX;
        v_end  = {1'b0, shadow_y_d} + BOX;
        in_box = shadow_en_d & video_on
               & (hcount >= shadow_x_d) & ({1'b0, hcount} < h_end)
               & (vcount >= shadow_y_d) & ({1'b0, vcount} < v_end);
        tex_x  = 4'((hcount - shadow_x_d) >> SCALE_LOG2);
        tex_y  = 4'((vcount - shadow_y_d) >> SCALE_LOG2);

        mem_x_d      = in_box ? tex_x : 4'd0;
        mem_y_d      = in_box ? tex_y : 4'd0;
        mem_shape_d  = shadow_shape_d;
        s0_d.in_box  = in_box;
        s0_d.vid     = video_on;
        s0_d.bg      = bg_rgb;
    end

    // Delay line so the pixel flags line up with the texel returned by memory.
    always_comb begin
        dly_d[0] = s0_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // Composite stage.
    always_comb begin
        al           = dly_q[MEM_LAT-1];
        vga_rgb_d    = 12'h000;
        sprite_hit_d = 1'b0;
        if (!al.vid) begin
            vga_rgb_d    = 12'h000;
            sprite_hit_d = 1'b0;
        end else if (al.in_box && mem_A) begin
            vga_rgb_d    = {{4{mem_R}}, {4{mem_G}}, {4{mem_B}}};
            sprite_hit_d = 1'b1;
        end else begin
            vga_rgb_d    = al.bg;
        end
        // A frame start beats a coincident hit.
        frame_drawn_d = frame_start ? 1'b0 : (frame_drawn_q | sprite_hit_d);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            shadow_x_q     <= '0;
            shadow_y_q     <= '0;
            shadow_shape_q <= '0;
            shadow_en_q    <= 1'b0;
            mem_x_q        <= '0;
            mem_y_q        <= '0;
            mem_shape_q    <= '0;
            s0_q           <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                dly_q[i] <= '0;
            end
            vga_rgb_q      <= '0;
            sprite_hit_q   <= 1'b0;
            frame_drawn_q  <= 1'b0;
        end else begin
            shadow_x_q     <= shadow_x_d;
            shadow_y_q     <= shadow_y_d;
            shadow_shape_q <= shadow_shape_d;
            shadow_en_q    <= shadow_en_d;
            mem_x_q        <= mem_x_d;
            mem_y_q        <= mem_y_d;
            mem_shape_q    <= mem_shape_d;
            s0_q           <= s0_d;
            for (int i = 0; i < MEM_LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
            vga_rgb_q      <= vga_rgb_d;
            sprite_hit_q   <= sprite_hit_d;
            frame_drawn_q  <= frame_drawn_d;
        end
    end

    assign mem_x       = mem_x_q;
    assign mem_y       = mem_y_q;
    assign mem_shape   = mem_shape_q;
    assign vga_rgb     = vga_rgb_q;
    assign sprite_hit  = sprite_hit_q;
    assign frame_drawn = frame_drawn_q;

endmodule
